// File: rtl/uart_tx_arbiter.sv
// Two byte sources share one uart_tx. Each source has a 1-deep holding register;
// a small FSM issues held bytes as single-cycle tx_en pulses and follows tx_busy.
module uart_tx_arbiter #(
    parameter int BUSY_TIMEOUT   = 16,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_en,
    input  logic       tx_busy,
    output logic       grant_id,
    output logic       active,
    output logic       timeout_err
);
    localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t           state, state_nxt;
    logic             held0, held1;
    logic [7:0]       buf0, buf1;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic             pick, winner, timeout_hit;

    always_comb begin
        state_nxt   = state;
        pick        = 1'b0;
        timeout_hit = 1'b0;
        // A lone holder wins outright; a tie goes against the previous grant
        winner = held1 & ~held0;
        if (held0 && held1)
            winner = (FIXED_PRIORITY != 0) ? 1'b0 : ~last;
        case (state)
            IDLE: begin
                if ((held0 || held1) && !tx_busy) begin
                    pick      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            held0    <= 1'b0;
            held1    <= 1'b0;
            last     <= 1'b1;
            grant_id <= 1'b0;
            tx_data  <= 8'h00;
            cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (pick) begin
                grant_id <= winner;
                last     <= winner;
                tx_data  <= winner ? buf1 : buf0;
            end
            if (state == ISSUE)
                cnt <= '0;
            else if (state == WAIT_BUSY && !tx_busy && !timeout_hit)
                cnt <= cnt + 1'b1;
            // The granted slot empties while its byte is being issued
            if (state == ISSUE && !grant_id)
                held0 <= 1'b0;
            else if (req0_valid && req0_ready)
                held0 <= 1'b1;
            if (state == ISSUE && grant_id)
                held1 <= 1'b0;
            else if (req1_valid && req1_ready)
                held1 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (req0_valid && req0_ready)
            buf0 <= req0_data;
        if (req1_valid && req1_ready)
            buf1 <= req1_data;
    end

    assign req0_ready  = ~held0;
    assign req1_ready  = ~held1;
    assign tx_en       = (state == ISSUE);
    assign active      = (state != IDLE);
    assign timeout_err = timeout_hit;

endmodule
